// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: data-memory op codes,
// LSU sequencer states and the RISC-V load/store funct3 encodings.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_e;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_HOLD = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] LED_MMIO_ADDR = 32'h0000_0100;

    // Halfword accesses need a 2-byte aligned address.
    function automatic logic op_is_half(input mem_op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    // Word accesses need a 4-byte aligned address.
    function automatic logic op_is_word(input mem_op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_ctrl_encode.sv
// Combinational translation of funct3 + read/write flags into the 4-bit
// data-memory control code, plus illegal-encoding and misalignment flags.
module lsu_ctrl_encode
    import riscv_mem_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [1:0] addr_lo,
    output logic [3:0] ctrl,
    output logic       illegal,
    output logic       misaligned
);

    mem_op_e op;
    logic    legal;

    // Decode the access type; anything outside the legal load/store set is flagged illegal.
    always_comb begin
        op         = OP_LB;
        legal      = 1'b0;
        if (mem_read && !mem_write) begin
            legal = 1'b1;
            case (funct3)
                F3_LB:   op = OP_LB;
                F3_LH:   op = OP_LH;
                F3_LW:   op = OP_LW;
                F3_LBU:  op = OP_LBU;
                F3_LHU:  op = OP_LHU;
                default: legal = 1'b0;
            endcase
        end else if (mem_write && !mem_read) begin
            legal = 1'b1;
            case (funct3)
                F3_SB:   op = OP_SB;
                F3_SH:   op = OP_SH;
                F3_SW:   op = OP_SW;
                default: legal = 1'b0;
            endcase
        end
        illegal    = (mem_read || mem_write) && !legal;
        ctrl       = legal ? {mem_read, op} : 4'b0000;
        misaligned = legal && ((op_is_half(op) && addr_lo[0]) ||
                               (op_is_word(op) && (addr_lo != 2'b00)));
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory accesses, sequences the
// two-cycle registered-RAM load, traps misaligned accesses and holds the
// MEM/WB pipeline register.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int ALLOW_MIS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_alu_result,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              mem_stall,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_ctrl,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign_exc,
    output logic [XLEN-1:0]   misalign_addr
);

    lsu_state_e        state_q, state_d;
    logic [XLEN-1:0]   hold_addr_q, hold_addr_d;
    logic [2:0]        hold_op_q, hold_op_d;
    logic              hold_rw_q, hold_rw_d;
    logic [REG_AW-1:0] hold_rd_q, hold_rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              exc_q, exc_d;
    logic [XLEN-1:0]   exc_addr_q, exc_addr_d;

    logic [3:0]        enc_ctrl;
    logic              enc_illegal;
    logic              enc_misaligned;
    logic              is_mem;
    logic              fault;

    lsu_ctrl_encode u_encode (
        .funct3     (ex_funct3),
        .mem_read   (ex_mem_read),
        .mem_write  (ex_mem_write),
        .addr_lo    (ex_alu_result[1:0]),
        .ctrl       (enc_ctrl),
        .illegal    (enc_illegal),
        .misaligned (enc_misaligned)
    );

    assign is_mem = ex_mem_read || ex_mem_write;
    assign fault  = enc_misaligned && (ALLOW_MIS == 0);

    // Next-state, MEM/WB update and data-memory drive for the load sequencer.
    always_comb begin
        state_d        = state_q;
        hold_addr_d    = hold_addr_q;
        hold_op_d      = hold_op_q;
        hold_rw_d      = hold_rw_q;
        hold_rd_d      = hold_rd_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        exc_d          = 1'b0;
        exc_addr_d     = exc_addr_q;
        dmem_addr      = ex_alu_result;
        dmem_wdata     = ex_store_data;
        dmem_ctrl      = 4'b0000;
        mem_stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mem && !enc_illegal && !fault && ex_mem_read) begin
                        // Load: hold the pipeline one cycle while the RAM output registers.
                        dmem_ctrl   = enc_ctrl;
                        mem_stall   = 1'b1;
                        hold_addr_d = ex_alu_result;
                        hold_op_d   = enc_ctrl[2:0];
                        hold_rw_d   = ex_reg_write && (ex_rd != '0);
                        hold_rd_d   = ex_rd;
                        state_d     = LOAD_HOLD;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_alu_result;
                        wb_reg_write_d = 1'b0;
                        if (!is_mem) begin
                            wb_reg_write_d = ex_reg_write;
                        end else if (fault) begin
                            exc_d      = 1'b1;
                            exc_addr_d = ex_alu_result;
                        end else if (!enc_illegal) begin
                            // Store: memory commits on this clock edge.
                            dmem_ctrl = enc_ctrl;
                        end
                    end
                end
            end
            LOAD_HOLD: begin
                // Memory formats the registered word using the latched address/op.
                dmem_addr      = hold_addr_q;
                dmem_ctrl      = {1'b1, hold_op_q};
                wb_valid_d     = 1'b1;
                wb_reg_write_d = hold_rw_q;
                wb_rd_d        = hold_rd_q;
                wb_data_d      = dmem_rdata;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // No memory access is issued while reset is held.
        if (!rst_n) begin
            dmem_ctrl = 4'b0000;
            mem_stall = 1'b0;
        end
    end

    // State, hold and MEM/WB registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hold_addr_q    <= '0;
            hold_op_q      <= '0;
            hold_rw_q      <= 1'b0;
            hold_rd_q      <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            exc_q          <= 1'b0;
            exc_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            hold_addr_q    <= hold_addr_d;
            hold_op_q      <= hold_op_d;
            hold_rw_q      <= hold_rw_d;
            hold_rd_q      <= hold_rd_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            exc_q          <= exc_d;
            exc_addr_q     <= exc_addr_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign misalign_exc  = exc_q;
    assign misalign_addr = exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a byte-addressed registered RAM model,
// an LED register at the MMIO address and a write-back scoreboard.
module tb_mem_stage_lsu;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_ctrl;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        chk;
        logic        exc;
        logic [31:0] eaddr;
    } wb_exp_t;
    wb_exp_t sbq[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .REG_AW(5), .ALLOW_MIS(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_funct3     (ex_funct3),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .mem_stall     (mem_stall),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ctrl     (dmem_ctrl),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .misalign_exc  (misalign_exc),
        .misalign_addr (misalign_addr)
    );

    // Data memory: word i holds i after reset; registered read, byte-lane stores.
    logic [31:0] mem [0:1023];
    logic [31:0] word_q;
    logic [31:0] led;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= i;
            led <= 32'h0;
        end else if (dmem_ctrl[3] == 1'b0) begin
            case (dmem_ctrl[2:0])
                3'b101: mem[dmem_addr[11:2]][{dmem_addr[1:0], 3'b000} +: 8]  <= dmem_wdata[7:0];
                3'b110: mem[dmem_addr[11:2]][{dmem_addr[1], 4'b0000} +: 16] <= dmem_wdata[15:0];
                3'b111: begin
                    mem[dmem_addr[11:2]] <= dmem_wdata;
                    if (dmem_addr == LED_MMIO_ADDR) led <= dmem_wdata;
                end
                default: ;
            endcase
        end
        word_q <= mem[dmem_addr[11:2]];
    end

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {24'h0, b};
            3'b010:  return {{16{h[15]}}, h};
            3'b011:  return {16'h0, h};
            3'b100:  return w;
            default: return 32'h0;
        endcase
    endfunction

    assign dmem_rdata = fmt(word_q, dmem_addr[1:0], dmem_ctrl[2:0]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic rw,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r);
        ex_valid      = v;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_reg_write  = rw;
        ex_funct3     = f3;
        ex_alu_result = a;
        ex_store_data = d;
        ex_rd         = r;
    endtask

    task automatic push(input logic [4:0] rd, input logic rw, input logic [31:0] data,
                        input logic chk, input logic exc, input logic [31:0] eaddr);
        wb_exp_t e;
        e.rd = rd; e.rw = rw; e.data = data; e.chk = chk; e.exc = exc; e.eaddr = eaddr;
        sbq.push_back(e);
    endtask

    // One cycle: check combinational memory-side outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic stall, input logic [3:0] ctrl, input logic [31:0] addr);
        @(negedge clk);
        check({tag, "_stall"}, mem_stall, stall);
        check({tag, "_ctrl"}, dmem_ctrl, ctrl);
        check({tag, "_addr"}, dmem_addr, addr);
        @(posedge clk);
        #1;
    endtask

    // Write-back monitor: every valid MEM/WB slot must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid === 1'b1) begin
                checks++;
                assert (sbq.size() > 0) else begin
                    errors++;
                    $error("FAIL wb_unexpected got wb_rd=%0d wb_data=%0h expected no write-back", wb_rd, wb_data);
                end
                if (sbq.size() > 0) begin
                    wb_exp_t e;
                    e = sbq.pop_front();
                    check("wb_reg_write", wb_reg_write, e.rw);
                    check("wb_exc", misalign_exc, e.exc);
                    if (e.exc) check("wb_exc_addr", misalign_addr, e.eaddr);
                    if (e.chk) begin
                        check("wb_rd", wb_rd, e.rd);
                        check("wb_data", wb_data, e.data);
                    end
                end
            end else begin
                check("exc_idle", misalign_exc, 1'b0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 3'b000, 32'h55AA_0010, 32'h0000_1111, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_reg_write", wb_reg_write, 1'b0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_exc", misalign_exc, 1'b0);
        check("rst_exc_addr", misalign_addr, 32'h0);
        check("rst_ctrl", dmem_ctrl, 4'b0000);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_addr", dmem_addr, 32'h55AA_0010);
        check("rst_wdata", dmem_wdata, 32'h0000_1111);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // LW x5, 0x010 -> 4; a different instruction during the hold cycle is ignored
        drive(1, 1, 0, 1, F3_LW, 32'h0000_0010, 32'h0, 5'd5);
        push(5'd5, 1'b1, 32'd4, 1'b1, 1'b0, 32'h0);
        cyc("lw_c1", 1'b1, 4'b1100, 32'h0000_0010);
        drive(1, 0, 0, 1, 3'b000, 32'hDEAD_0000, 32'h0, 5'd7);
        cyc("lw_c2", 1'b0, 4'b1100, 32'h0000_0010);
        drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        cyc("idle1", 1'b0, 4'b0000, 32'h0);

        // SW 0x7ABC to the LED register
        drive(1, 0, 1, 0, F3_SW, LED_MMIO_ADDR, 32'h0000_7ABC, 5'd0);
        push(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("sw", 1'b0, 4'b0111, LED_MMIO_ADDR);
        check("led", led, 32'h0000_7ABC);

        // SB 0x80 at 0x011, then sign/zero-extended byte loads
        drive(1, 0, 1, 0, F3_SB, 32'h0000_0011, 32'h0000_0080, 5'd0);
        push(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("sb", 1'b0, 4'b0101, 32'h0000_0011);
        drive(1, 1, 0, 1, F3_LB, 32'h0000_0011, 32'h0, 5'd6);
        push(5'd6, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 32'h0);
        cyc("lb_c1", 1'b1, 4'b1000, 32'h0000_0011);
        cyc("lb_c2", 1'b0, 4'b1000, 32'h0000_0011);
        drive(1, 1, 0, 1, F3_LBU, 32'h0000_0011, 32'h0, 5'd7);
        push(5'd7, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
        cyc("lbu_c1", 1'b1, 4'b1001, 32'h0000_0011);
        cyc("lbu_c2", 1'b0, 4'b1001, 32'h0000_0011);

        // Misaligned LH at 0x003: no access, no stall, exception pulse
        drive(1, 1, 0, 1, F3_LH, 32'h0000_0003, 32'h0, 5'd8);
        push(5'd8, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0003);
        cyc("lh_mis", 1'b0, 4'b0000, 32'h0000_0003);

        // Illegal funct3 load, then read+write both set
        drive(1, 1, 0, 1, 3'b011, 32'h0000_0020, 32'h0, 5'd9);
        push(5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("ill_f3", 1'b0, 4'b0000, 32'h0000_0020);
        drive(1, 1, 1, 1, F3_LW, 32'h0000_0020, 32'h0, 5'd9);
        push(5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc("ill_rw", 1'b0, 4'b0000, 32'h0000_0020);
        check("exc_addr_held", misalign_addr, 32'h0000_0003);

        // LW; LW; ADD back-to-back
        drive(1, 1, 0, 1, F3_LW, 32'h0000_0020, 32'h0, 5'd1);
        push(5'd1, 1'b1, 32'd8, 1'b1, 1'b0, 32'h0);
        cyc("b2b_lw1_c1", 1'b1, 4'b1100, 32'h0000_0020);
        cyc("b2b_lw1_c2", 1'b0, 4'b1100, 32'h0000_0020);
        drive(1, 1, 0, 1, F3_LW, 32'h0000_0024, 32'h0, 5'd2);
        push(5'd2, 1'b1, 32'd9, 1'b1, 1'b0, 32'h0);
        cyc("b2b_lw2_c1", 1'b1, 4'b1100, 32'h0000_0024);
        cyc("b2b_lw2_c2", 1'b0, 4'b1100, 32'h0000_0024);
        drive(1, 0, 0, 1, 3'b000, 32'h0000_1234, 32'h0, 5'd3);
        push(5'd3, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 32'h0);
        cyc("b2b_add", 1'b0, 4'b0000, 32'h0000_1234);
        drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        cyc("idle2", 1'b0, 4'b0000, 32'h0);
        check("hold_wb_data", wb_data, 32'h0000_1234);
        check("hold_wb_rd", wb_rd, 5'd3);

        // Load to x0: access performed, write-back disabled; word 4 now carries the SB byte
        drive(1, 1, 0, 1, F3_LW, 32'h0000_0010, 32'h0, 5'd0);
        push(5'd0, 1'b0, 32'h0000_8004, 1'b1, 1'b0, 32'h0);
        cyc("lw_x0_c1", 1'b1, 4'b1100, 32'h0000_0010);
        cyc("lw_x0_c2", 1'b0, 4'b1100, 32'h0000_0010);
        drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        cyc("idle3", 1'b0, 4'b0000, 32'h0);
        @(negedge clk);
        check("sb_empty_mid", sbq.size(), 32'd0);
        @(posedge clk);
        #1;

        // Reset asserted in the load hold cycle
        drive(1, 1, 0, 1, F3_LW, 32'h0000_0014, 32'h0, 5'd4);
        cyc("rst_lw_c1", 1'b1, 4'b1100, 32'h0000_0014);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_hold_ctrl", dmem_ctrl, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 1, 3'b000, 32'h0000_0077, 32'h0, 5'd10);
        push(5'd10, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_hold_wb_valid", wb_valid, 1'b0);
        check("rst_hold_idle_stall", mem_stall, 1'b0);
        check("rst_hold_idle_ctrl", dmem_ctrl, 4'b0000);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("sb_empty_end", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
